// File: rtl/block_memory_responder.sv
// Block-organised memory responder for the data-cache memRen/memWen handshake.
// Services one whole-block read or write at a time with fixed latency and single-cycle completion pulses.
module block_memory_responder #(
  parameter int BLOCK_ADDR_WIDTH = 10,
  parameter int BLOCK_WIDTH      = 256,
  parameter int READ_LATENCY     = 10,
  parameter int WRITE_LATENCY    = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        memRen,
  input  logic                        memWen,
  input  logic [BLOCK_ADDR_WIDTH-1:0] memBlockAddr,
  input  logic [BLOCK_WIDTH-1:0]      memDin,
  output logic                        memReadReady,
  output logic                        memWriteDone,
  output logic [BLOCK_WIDTH-1:0]      memDout
);

  localparam int DEPTH = 2 ** BLOCK_ADDR_WIDTH;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] READ_WAIT  = 2'd1;
  localparam logic [1:0] WRITE_WAIT = 2'd2;
  localparam logic [1:0] RELEASE    = 2'd3;

  logic [1:0]                  state;
  logic [7:0]                  counter;
  logic [BLOCK_ADDR_WIDTH-1:0] capAddr;
  logic [BLOCK_WIDTH-1:0]      capData;
  logic                        servicedWrite;
  logic                        storeWen;

  logic [BLOCK_WIDTH-1:0] store [0:DEPTH-1];

  // Commit happens on the edge where the write countdown expires; a reset on that edge discards it.
  assign storeWen = (state == WRITE_WAIT) && (counter == '0) && !reset;

  // NOTE: the backing store has no reset branch so it maps onto RAM and keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (storeWen) begin
      store[capAddr] <= capData;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      capAddr       <= '0;
      capData       <= '0;
      servicedWrite <= 1'b0;
      memReadReady  <= 1'b0;
      memWriteDone  <= 1'b0;
      memDout       <= '0;
    end else begin
      memReadReady <= 1'b0;
      memWriteDone <= 1'b0;

      case (state)
        IDLE: begin
          // Write wins so a dirty-block writeback lands before the fill that replaces it.
          if (memWen) begin
            capAddr       <= memBlockAddr;
            capData       <= memDin;
            counter       <= 8'(WRITE_LATENCY - 1);
            servicedWrite <= 1'b1;
            state         <= WRITE_WAIT;
          end else if (memRen) begin
            capAddr       <= memBlockAddr;
            counter       <= 8'(READ_LATENCY - 1);
            servicedWrite <= 1'b0;
            state         <= READ_WAIT;
          end
        end

        READ_WAIT: begin
          if (counter == '0) begin
            memDout      <= store[capAddr];
            memReadReady <= 1'b1;
            state        <= memRen ? RELEASE : IDLE;
          end else begin
            counter <= counter - 8'd1;
          end
        end

        WRITE_WAIT: begin
          if (counter == '0) begin
            memWriteDone <= 1'b1;
            state        <= memWen ? RELEASE : IDLE;
          end else begin
            counter <= counter - 8'd1;
          end
        end

        RELEASE: begin
          // Hold off until the serviced level request drops so it is never serviced twice.
          if (!(servicedWrite ? memWen : memRen)) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/block_memory_responder.md
Name: block_memory_responder

Overview:
- Main-memory responder on the block interface driven by the data-cache controller; it is the memory end of the memRen/memWen/memReadReady/memWriteDone handshake.
- Holds a block-organised backing store.
- Services one whole-block read or write at a time with fixed, parameterised latency.
- Returns single-cycle completion pulses; serves as both the simulation memory model and the synthesisable off-chip memory stand-in.

Parameters:
- BLOCK_ADDR_WIDTH, 10, width of the block address; store depth = 2**BLOCK_ADDR_WIDTH blocks.
- BLOCK_WIDTH, 256, bits per cache block (8 x 32-bit words).
- READ_LATENCY, 10, cycles from read acceptance to memReadReady; legal range 1..255.
- WRITE_LATENCY, 10, cycles from write acceptance to memWriteDone; legal range 1..255.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- memRen, input, 1, block read request (level, held by requester until memReadReady).
- memWen, input, 1, block write request (level, held by requester until memWriteDone).
- memBlockAddr, input, BLOCK_ADDR_WIDTH, block address of the request.
- memDin, input, BLOCK_WIDTH, write data block.
- memReadReady, output, 1, one-cycle pulse: read complete, memDout valid.
- memWriteDone, output, 1, one-cycle pulse: write committed to store.
- memDout, output, BLOCK_WIDTH, read data block.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: memReadReady=0, memWriteDone=0, memDout=0, state=IDLE, counter=0, captured addr/data=0. Store contents are not cleared by reset.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELEASE.
- IDLE:
  - memWen=1 at an edge: capture memBlockAddr and memDin, counter<=WRITE_LATENCY-1, go to WRITE_WAIT.
  - Else memRen=1: capture memBlockAddr, counter<=READ_LATENCY-1, go to READ_WAIT.
  - Write has priority when both requests are asserted, so writeback precedes fill. The read stays pending and is accepted after the write completes and returns to IDLE.
- READ_WAIT / WRITE_WAIT:
  - Counter decrements each cycle.
  - When counter==0 at an edge:
    - Read: memDout<=store[captured addr], memReadReady<=1.
    - Write: store[captured addr]<=captured data, memWriteDone<=1.
  - Then go to RELEASE if the serviced request is still high, else to IDLE.
- Latency: request sampled at edge E0 → completion pulse high for exactly the cycle after edge E0+LATENCY. Example: READ_LATENCY=1 means the pulse is high in the cycle right after acceptance.
- Pulses: memReadReady and memWriteDone are high for exactly one cycle and are never high simultaneously.
- memDout holds the last read block until the next read completion; it is unchanged by writes.
- Captured addr/data are frozen for the whole operation. Changes on memBlockAddr, memDin or the other request line during the wait are ignored.
- Request dropped mid-operation: the operation still completes, and its pulse and store update still occur (no abort).
- RELEASE: waits for the serviced request line to go low, then returns to IDLE. A held request is never serviced twice. The other request line is ignored while in RELEASE.
- Read-after-write to the same block returns the newly written data; write commit precedes any later read acceptance.
- Reset asserted mid-operation: the operation is discarded, no pulse and no store write occur, and all outputs return to reset values at that edge.
- Address is always in range by construction (full decode of BLOCK_ADDR_WIDTH).

Test Plan:
- Reset: hold reset 3 cycles with memRen=1 → memReadReady=0, memWriteDone=0, memDout=0 throughout; after release, read accepted on the first edge.
- Write then read (WRITE_LATENCY=4, READ_LATENCY=4): write addr 0x015 data {8{32'hA5A5_0001}} → memWriteDone high exactly 4 cycles after acceptance for 1 cycle. Drop memWen, read 0x015 → memReadReady high 4 cycles later with memDout={8{32'hA5A5_0001}}.
- Simultaneous request: memRen=memWen=1, addr 0x020, data pattern P, store[0x020]=0 → memWriteDone pulse first. Requester drops memWen and keeps memRen → memReadReady later with memDout=P.
- Held request: keep memRen high 20 cycles after memReadReady → exactly one pulse observed; no second access until memRen toggles low then high.
- Mid-operation changes: change memBlockAddr 0x001→0x3FF and memDin during WRITE_WAIT → only block 0x001 is updated with the originally captured data; block 0x3FF is unchanged.
- Reset mid-read: assert reset 2 cycles into a READ_LATENCY=10 read → no memReadReady ever; memDout=0; a new read after reset completes normally with full latency.
